// File: rtl/add_sub_calc_ctrl.sv
// Operand-entry and sequencing controller for the 4-bit add/sub calculator.
// Conditions the enter/clear buttons and steps A -> B -> settle -> show.
module add_sub_calc_ctrl #(
   parameter int DEBOUNCE   = 4,
   parameter int SETTLE_CYC = 2
) (
   input  logic       sys_clk,
   input  logic       reset,
   input  logic [3:0] sw,
   input  logic       sw_op,
   input  logic       btn_enter,
   input  logic       btn_clear,
   input  logic [4:0] res_in,
   output logic [3:0] op_a,
   output logic [3:0] op_b,
   output logic       op_sel,
   output logic [7:0] disp_val,
   output logic [3:0] state_led,
   output logic       busy,
   output logic       result_valid
);

   localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE - 1);
   localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_CYC - 1);

   typedef enum logic [1:0] {S_A = 2'd0, S_B = 2'd1, S_CALC = 2'd2, S_SHOW = 2'd3} state_t;

   // Bit 0 is enter, bit 1 is clear.
   logic [1:0]          raw_s;
   logic [1:0]          s1_q, s2_q, stable_q, stable_d, edge_q, press_s;
   logic [1:0][DW-1:0]  cnt_q, cnt_d;
   logic                enter_s, clear_s;

   state_t         state_q, state_d;
   logic [3:0]     op_a_q, op_a_d, op_b_q, op_b_d;
   logic           op_sel_q, op_sel_d;
   logic [7:0]     disp_q, disp_d;
   logic [4:0]     result_q, result_d;
   logic [CW-1:0]  settle_q, settle_d;

   assign raw_s   = {btn_clear, btn_enter};
   assign press_s = stable_q & ~edge_q;
   assign enter_s = press_s[0];
   assign clear_s = press_s[1];

   // Debounce: accept a new level only after DEBOUNCE consecutive differing cycles.
   always_comb begin
      cnt_d    = cnt_q;
      stable_d = stable_q;
      for (int i = 0; i < 2; i++) begin
         if (s2_q[i] == stable_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == DEB_LAST) begin
            stable_d[i] = s2_q[i];
            cnt_d[i]    = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + DW'(1);
         end
      end
   end

   // Button synchronizers, debounce state and edge-detect history.
   always_ff @(posedge sys_clk or negedge reset) begin
      if (!reset) begin
         s1_q     <= 2'b00;
         s2_q     <= 2'b00;
         cnt_q    <= '0;
         stable_q <= 2'b00;
         edge_q   <= 2'b00;
      end else begin
         s1_q     <= raw_s;
         s2_q     <= s1_q;
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
         edge_q   <= stable_q;
      end
   end

   // Sequencer next state and datapath register updates; clear overrides everything.
   always_comb begin
      state_d  = state_q;
      op_a_d   = op_a_q;
      op_b_d   = op_b_q;
      op_sel_d = op_sel_q;
      disp_d   = disp_q;
      result_d = result_q;
      settle_d = settle_q;
      case (state_q)
         S_A: begin
            disp_d = {4'b0000, sw};
            if (enter_s) begin
               op_a_d  = sw;
               state_d = S_B;
            end else begin
               state_d = S_A;
            end
         end
         S_B: begin
            disp_d = {4'b0000, sw};
            if (enter_s) begin
               op_b_d   = sw;
               op_sel_d = sw_op;
               settle_d = '0;
               state_d  = S_CALC;
            end else begin
               state_d = S_B;
            end
         end
         S_CALC: begin
            settle_d = settle_q + CW'(1);
            if (settle_q == SET_LAST) begin
               result_d = res_in;
               disp_d   = {3'b000, res_in};
               state_d  = S_SHOW;
            end else begin
               state_d = S_CALC;
            end
         end
         S_SHOW: begin
            disp_d = {3'b000, result_q};
            if (enter_s) begin
               state_d = S_A;
            end else begin
               state_d = S_SHOW;
            end
         end
         default: begin
            state_d = S_A;
         end
      endcase
      if (clear_s) begin
         state_d  = S_A;
         op_a_d   = 4'h0;
         op_b_d   = 4'h0;
         op_sel_d = 1'b0;
         result_d = 5'h00;
         settle_d = '0;
      end else begin
         state_d = state_d;
      end
   end

   // Sequencer and datapath-facing registers.
   always_ff @(posedge sys_clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_A;
         op_a_q   <= 4'h0;
         op_b_q   <= 4'h0;
         op_sel_q <= 1'b0;
         disp_q   <= 8'h00;
         result_q <= 5'h00;
         settle_q <= '0;
      end else begin
         state_q  <= state_d;
         op_a_q   <= op_a_d;
         op_b_q   <= op_b_d;
         op_sel_q <= op_sel_d;
         disp_q   <= disp_d;
         result_q <= result_d;
         settle_q <= settle_d;
      end
   end

   // One-hot state decode for the LEDs.
   always_comb begin
      case (state_q)
         S_A:     state_led = 4'b0001;
         S_B:     state_led = 4'b0010;
         S_CALC:  state_led = 4'b0100;
         S_SHOW:  state_led = 4'b1000;
         default: state_led = 4'b0001;
      endcase
   end

   assign busy         = (state_q == S_CALC);
   assign result_valid = (state_q == S_SHOW);
   assign op_a         = op_a_q;
   assign op_b         = op_b_q;
   assign op_sel       = op_sel_q;
   assign disp_val     = disp_q;

endmodule
